// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multiport register file slice.
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 31;

  // Low bit of lane idx inside a packed bus of w-bit lanes.
  function automatic int sliceLo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode-side bus of the register file: read ports, write port, pending marks.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) ();

  // No valid/ready here: writes and pending marks are always accepted on the
  // edge they are presented, and RStall is advisory for the consumer only.
  logic [NUM_RD*ADDR_W-1:0] RAddr;
  logic [NUM_RD*DATA_W-1:0] RData;
  logic [NUM_RD-1:0]        RStall;
  logic [ADDR_W-1:0]        RW;
  logic [DATA_W-1:0]        BusW;
  logic                     RegWr;
  logic                     SetPend;
  logic [ADDR_W-1:0]        PendReg;
  logic [(1<<ADDR_W)-1:0]   PendVec;

  modport master (
    output RAddr, RW, BusW, RegWr, SetPend, PendReg,
    input  RData, RStall, PendVec
  );

  modport slave (
    input  RAddr, RW, BusW, RegWr, SetPend, PendReg,
    output RData, RStall, PendVec
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write bits, one per register, plus per-read-port stall decode.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_REG  = DEF_ZERO_REG,
  parameter int BYPASS_EN = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     regWr,
  input  logic [ADDR_W-1:0]        rw,
  input  logic                     setPend,
  input  logic [ADDR_W-1:0]        pendReg,
  input  logic [NUM_RD*ADDR_W-1:0] rAddr,
  output logic [NUM_RD-1:0]        rStall,
  output logic [(1<<ADDR_W)-1:0]   pendVec
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pendNext;
  logic             wrZero;
  logic             setZero;

  assign wrZero  = (ZERO_EN != 0) && (rw == ZADDR);
  assign setZero = (ZERO_EN != 0) && (pendReg == ZADDR);

  // Clear first, then set, so a new producer issued on the completing
  // write's cycle keeps ownership of the register.
  always_comb begin
    pendNext = pend;
    if (regWr && !wrZero) pendNext[rw] = 1'b0;
    if (setPend && !setZero) pendNext[pendReg] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) pend <= '0;
    else       pend <= pendNext;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    a      = '0;
    rStall = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rAddr[sliceLo(i, ADDR_W) +: ADDR_W];
      rStall[i] = pend[a]
                  && !((ZERO_EN != 0) && (a == ZADDR))
                  && !((BYPASS_EN != 0) && regWr && (rw == a));
    end
  end

  assign pendVec = pend;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised N-read/1-write register file with zero register, bypass and pending scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_REG  = DEF_ZERO_REG,
  parameter int BYPASS_EN = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  regfile_multiport_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rdPacked;
  logic                     wrZero;

  assign wrZero = (ZERO_EN != 0) && (bus.RW == ZADDR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (bus.RegWr && !wrZero) begin
      mem[bus.RW] <= bus.BusW;
    end
  end

  // Zero register outranks bypass so a write aimed at it never leaks out.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a        = '0;
    rdPacked = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = bus.RAddr[sliceLo(i, ADDR_W) +: ADDR_W];
      if ((ZERO_EN != 0) && (a == ZADDR))
        rdPacked[sliceLo(i, DATA_W) +: DATA_W] = '0;
      else if ((BYPASS_EN != 0) && bus.RegWr && (bus.RW == a))
        rdPacked[sliceLo(i, DATA_W) +: DATA_W] = bus.BusW;
      else
        rdPacked[sliceLo(i, DATA_W) +: DATA_W] = mem[a];
    end
  end

  assign bus.RData = rdPacked;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_EN  (ZERO_EN),
    .ZERO_REG (ZERO_REG),
    .BYPASS_EN(BYPASS_EN)
  ) uScoreboard (
    .Clk    (Clk),
    .Reset  (Reset),
    .regWr  (bus.RegWr),
    .rw     (bus.RW),
    .setPend(bus.SetPend),
    .pendReg(bus.PendReg),
    .rAddr  (bus.RAddr),
    .rStall (bus.RStall),
    .pendVec(bus.PendVec)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed plus randomized bench for regfile_multiport against an array-based reference model.
module tb_regfile_multiport;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int ZR    = 31;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
        .ZERO_EN(1), .ZERO_REG(ZR), .BYPASS_EN(1)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    logic [DW-1:0] refMem [DEPTH];
    bit            refPend [DEPTH];
    int            rdAddr [NR];
    int            checks = 0;
    int            errors = 0;

    task automatic setRead(input int a0, input int a1);
        rdAddr[0] = a0;
        rdAddr[1] = a1;
        bus.RAddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic setWrite(input bit we, input int rw, input logic [DW-1:0] d);
        bus.RegWr = we;
        bus.RW    = AW'(rw);
        bus.BusW  = d;
    endtask

    task automatic setPendMark(input bit sp, input int pr);
        bus.SetPend = sp;
        bus.PendReg = AW'(pr);
    endtask

    function automatic logic [DW-1:0] expRead(input int a);
        if (a == ZR) return '0;
        if (bus.RegWr && int'(bus.RW) == a) return bus.BusW;
        return refMem[a];
    endfunction

    function automatic logic expStall(input int a);
        if (a == ZR) return 1'b0;
        if (bus.RegWr && int'(bus.RW) == a) return 1'b0;
        return refPend[a];
    endfunction

    task automatic checkEq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge, once inputs for the coming edge are set.
    task automatic checkAll(input string tag);
        logic [DEPTH-1:0] pv;
        #1;
        for (int p = 0; p < NR; p++) begin
            checkEq($sformatf("%s_rdata%0d", tag, p), bus.RData[p*DW +: DW], expRead(rdAddr[p]));
            checkEq($sformatf("%s_stall%0d", tag, p), DW'(bus.RStall[p]), DW'(expStall(rdAddr[p])));
        end
        for (int r = 0; r < DEPTH; r++) pv[r] = refPend[r];
        checkEq($sformatf("%s_pendvec", tag), DW'(bus.PendVec), DW'(pv));
    endtask

    // Advance one clock; the model applies the rules to the inputs held across the edge.
    task automatic tick();
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                refMem[r]  = '0;
                refPend[r] = 1'b0;
            end
        end else begin
            if (bus.RegWr && int'(bus.RW) != ZR) begin
                refMem[bus.RW]  = bus.BusW;
                refPend[bus.RW] = 1'b0;
            end
            if (bus.SetPend && int'(bus.PendReg) != ZR) refPend[bus.PendReg] = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle();
        setWrite(1'b0, 0, '0);
        setPendMark(1'b0, 0);
    endtask

    initial begin
        for (int r = 0; r < DEPTH; r++) begin
            refMem[r]  = 'x;
            refPend[r] = 1'b0;
        end
        Reset = 1'b1;
        idle();
        setRead(0, 0);
        tick();
        Reset = 1'b0;

        setRead(3, 31);
        checkAll("reset");
        checkEq("reset_rstall_const", DW'(bus.RStall), '0);

        setWrite(1'b1, 5, 64'hDEAD_BEEF_0000_0001);
        setRead(5, 0);
        checkAll("bypass5");
        checkEq("bypass5_const", bus.RData[0 +: DW], 64'hDEAD_BEEF_0000_0001);
        tick();
        idle();
        checkAll("stored5");
        checkEq("stored5_const", bus.RData[0 +: DW], 64'hDEAD_BEEF_0000_0001);

        setWrite(1'b1, 31, '1);
        setRead(31, 5);
        checkAll("zero_wr");
        checkEq("zero_wr_const", bus.RData[0 +: DW], '0);
        tick();
        idle();
        checkAll("zero_after");
        checkEq("zero_after_const", bus.RData[0 +: DW], '0);
        checkEq("zero_other_const", bus.RData[DW +: DW], 64'hDEAD_BEEF_0000_0001);

        setPendMark(1'b1, 7);
        tick();
        idle();
        setRead(0, 7);
        checkAll("pend7");
        checkEq("pend7_stall_const", DW'(bus.RStall[1]), 64'd1);
        setWrite(1'b1, 7, 64'd42);
        checkAll("pend7_byp");
        checkEq("pend7_byp_data", bus.RData[DW +: DW], 64'd42);
        checkEq("pend7_byp_stall", DW'(bus.RStall[1]), 64'd0);
        tick();
        idle();
        checkAll("pend7_clr");
        checkEq("pend7_clr_bit", DW'(bus.PendVec[7]), 64'd0);

        setPendMark(1'b1, 9);
        setWrite(1'b1, 9, 64'd10);
        tick();
        idle();
        setRead(9, 9);
        checkAll("set_wins");
        checkEq("set_wins_data", bus.RData[0 +: DW], 64'd10);
        checkEq("set_wins_bit", DW'(bus.PendVec[9]), 64'd1);
        checkEq("set_wins_stall", DW'(bus.RStall), 64'd3);

        setPendMark(1'b1, 4);
        setWrite(1'b1, 6, 64'h55);
        tick();
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        setRead(6, 4);
        checkAll("midreset");
        checkEq("midreset_pend", DW'(bus.PendVec), '0);
        checkEq("midreset_mem6", bus.RData[0 +: DW], '0);
        checkEq("midreset_stall", DW'(bus.RStall), '0);

        for (int n = 0; n < 400; n++) begin
            Reset = ($urandom_range(0, 49) == 0);
            setWrite(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), {$urandom, $urandom});
            setPendMark(($urandom_range(0, 2) == 0), $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) setRead(int'(bus.RW), $urandom_range(0, DEPTH - 1));
            else setRead($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            if (!Reset) checkAll($sformatf("rand%0d", n));
            tick();
        end
        Reset = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
